// File: rtl/parking_exit_if.sv
// parking_exit_if: exit request, occupancy and gate status signals of the parking exit gate.
interface parking_exit_if #(
  parameter int SLOTS = 4,
  parameter int SLOT_W = 2
);
  logic exit_req;
  logic [SLOT_W-1:0] exit_slot;
  logic [SLOTS-1:0] occupied;
  logic car_passed;
  logic release_valid;
  logic [SLOT_W-1:0] release_slot;
  logic gate_open;
  logic exit_door_light;
  logic error_light;
  logic [7:0] exits_count;
  logic [2:0] state;
  modport master (
    output exit_req, exit_slot, occupied, car_passed,
    input release_valid, release_slot, gate_open, exit_door_light, error_light, exits_count, state
  );
  modport slave (
    input exit_req, exit_slot, occupied, car_passed,
    output release_valid, release_slot, gate_open, exit_door_light, error_light, exits_count, state
  );
endinterface

// File: rtl/parking_exit_gate.sv
// parking_exit_gate: validates an exit slot, opens the gate with a blinking light and releases the slot once the car has passed.
module parking_exit_gate #(
  parameter int SLOTS = 4,
  parameter int SLOT_W = 2,
  parameter int OPEN_CYCLES = 50,
  parameter int ERR_CYCLES = 14,
  parameter int BLINK_DIV = 2
) (
  input logic clk,
  input logic reset,
  parking_exit_if.slave gate_if
);
  localparam int TMAX = OPEN_CYCLES > ERR_CYCLES ? OPEN_CYCLES : ERR_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int NS = 2 ** SLOT_W;
  typedef enum logic [2:0] {IDLE = 3'd0, CHECK = 3'd1, OPEN = 3'd2, ERROR = 3'd3} state_e;
  state_e state_q;
  logic req_q, rel_q, gate_q, door_q, err_q;
  logic [SLOT_W-1:0] slot_q;
  logic [TW-1:0] tmr_q;
  logic [BW-1:0] blk_q;
  logic [7:0] cnt_q;
  logic [NS-1:0] occ_ext;
  logic req_edge, blk_wrap, slot_ok, open_end, err_end;
  // zero-padding the bitmap makes any index >= SLOTS read as empty
  assign occ_ext = NS'(gate_if.occupied);
  assign req_edge = gate_if.exit_req & ~req_q;
  assign blk_wrap = blk_q == BW'(BLINK_DIV - 1);
  assign slot_ok = occ_ext[slot_q];
  assign open_end = gate_if.car_passed || tmr_q == TW'(OPEN_CYCLES - 1);
  assign err_end = tmr_q == TW'(ERR_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      rel_q <= 1'b0;
      gate_q <= 1'b0;
      door_q <= 1'b0;
      err_q <= 1'b0;
      slot_q <= '0;
      tmr_q <= '0;
      blk_q <= '0;
      cnt_q <= '0;
    end else begin
      req_q <= gate_if.exit_req;
      rel_q <= 1'b0;
      case (state_q)
        IDLE: if (req_edge) begin
          slot_q <= gate_if.exit_slot;
          state_q <= CHECK;
        end
        CHECK: begin
          tmr_q <= '0;
          blk_q <= '0;
          door_q <= 1'b0;
          err_q <= 1'b0;
          gate_q <= slot_ok;
          state_q <= slot_ok ? OPEN : ERROR;
        end
        OPEN: begin
          tmr_q <= tmr_q + 1'b1;
          blk_q <= blk_wrap ? '0 : blk_q + 1'b1;
          door_q <= door_q ^ blk_wrap;
          if (open_end) begin
            state_q <= IDLE;
            gate_q <= 1'b0;
            door_q <= 1'b0;
            rel_q <= gate_if.car_passed;
            if (gate_if.car_passed && cnt_q != 8'hFF) cnt_q <= cnt_q + 1'b1;
          end
        end
        ERROR: begin
          tmr_q <= tmr_q + 1'b1;
          blk_q <= blk_wrap ? '0 : blk_q + 1'b1;
          err_q <= err_end ? 1'b0 : err_q ^ blk_wrap;
          if (err_end) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          gate_q <= 1'b0;
          door_q <= 1'b0;
          err_q <= 1'b0;
        end
      endcase
    end
  assign gate_if.release_valid = rel_q;
  assign gate_if.release_slot = slot_q;
  assign gate_if.gate_open = gate_q;
  assign gate_if.exit_door_light = door_q;
  assign gate_if.error_light = err_q;
  assign gate_if.exits_count = cnt_q;
  assign gate_if.state = state_q;
endmodule
